// File: rtl/need_event_scheduler.sv
// Pet "need" event scheduler: prescaled interval timer, random need choice,
// valid/ack offer to the display engine, then service-or-timeout tracking.
module need_event_scheduler #(
  parameter int TICK_DIV = 50_000_000,
  parameter int INTERVAL = 10,
  parameter int TIMEOUT  = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic [1:0] rand_in,
  output logic       need_valid,
  output logic [1:0] need_type,
  input  logic       need_ack,
  output logic       need_active,
  input  logic       serviced,
  input  logic [1:0] serviced_type,
  output logic       done_pulse,
  output logic       miss_pulse,
  output logic [7:0] miss_count,
  output logic [1:0] state_dbg
);

  // Handshake: need_valid is held in ISSUE until a cycle with need_ack=1;
  // the transfer happens on that edge and need_valid drops on the same edge.
  // need_ack is ignored in every other state.

  localparam int PW = $clog2(TICK_DIV);
  localparam int IW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [IW-1:0] IVL_LAST  = IW'(INTERVAL - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ISSUE  = 2'd2,
    S_ACTIVE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] ivl_q,   ivl_d;
  logic [TW-1:0] to_q,    to_d;
  logic [1:0]    type_q,  type_d;
  logic          done_q,  done_d;
  logic          miss_q,  miss_d;
  logic [7:0]    mc_q,    mc_d;
  logic          tick;
  logic          service_ok;

  assign tick       = ((state_q == S_WAIT) || (state_q == S_ACTIVE)) && (presc_q == PRESC_MAX);
  assign service_ok = serviced && (serviced_type == type_q);

  always_comb begin
    state_d = state_q;
    presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
    ivl_d   = ivl_q;
    to_d    = to_q;
    type_d  = type_q;
    done_d  = 1'b0;
    miss_d  = 1'b0;
    mc_d    = mc_q;

    if (!enable) begin
      // Game stopped: everything but the miss history is discarded.
      state_d = S_IDLE;
      presc_d = '0;
      ivl_d   = '0;
      to_d    = '0;
      type_d  = 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_WAIT;
          presc_d = '0;
          ivl_d   = '0;
        end
        S_WAIT: begin
          if (tick) begin
            if (ivl_q == IVL_LAST) begin
              type_d  = rand_in;
              state_d = S_ISSUE;
              presc_d = '0;
            end else begin
              ivl_d = ivl_q + IW'(1);
            end
          end
        end
        S_ISSUE: begin
          if (need_ack) begin
            state_d = S_ACTIVE;
            to_d    = '0;
            presc_d = '0;
          end
        end
        S_ACTIVE: begin
          // Correct service takes priority over a coincident timeout tick.
          if (service_ok) begin
            done_d  = 1'b1;
            state_d = S_WAIT;
            ivl_d   = '0;
            presc_d = '0;
          end else if (tick) begin
            if (to_q == TO_LAST) begin
              miss_d  = 1'b1;
              mc_d    = (mc_q == 8'hFF) ? mc_q : mc_q + 8'd1;
              state_d = S_WAIT;
              ivl_d   = '0;
              presc_d = '0;
            end else begin
              to_d = to_q + TW'(1);
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          presc_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      ivl_q   <= '0;
      to_q    <= '0;
      type_q  <= 2'd0;
      done_q  <= 1'b0;
      miss_q  <= 1'b0;
      mc_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      ivl_q   <= ivl_d;
      to_q    <= to_d;
      type_q  <= type_d;
      done_q  <= done_d;
      miss_q  <= miss_d;
      mc_q    <= mc_d;
    end
  end

  assign need_valid  = (state_q == S_ISSUE);
  assign need_active = (state_q == S_ACTIVE);
  assign need_type   = type_q;
  assign done_pulse  = done_q;
  assign miss_pulse  = miss_q;
  assign miss_count  = mc_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_need_event_scheduler.sv
// Directed bench for need_event_scheduler with TICK_DIV=4, INTERVAL=3, TIMEOUT=2.
module tb_need_event_scheduler;

  logic       clk;
  logic       resetn;
  logic       enable;
  logic [1:0] rand_in;
  logic       need_valid;
  logic [1:0] need_type;
  logic       need_ack;
  logic       need_active;
  logic       serviced;
  logic [1:0] serviced_type;
  logic       done_pulse;
  logic       miss_pulse;
  logic [7:0] miss_count;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;

  need_event_scheduler #(
    .TICK_DIV(4),
    .INTERVAL(3),
    .TIMEOUT (2)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .enable       (enable),
    .rand_in      (rand_in),
    .need_valid   (need_valid),
    .need_type    (need_type),
    .need_ack     (need_ack),
    .need_active  (need_active),
    .serviced     (serviced),
    .serviced_type(serviced_type),
    .done_pulse   (done_pulse),
    .miss_pulse   (miss_pulse),
    .miss_count   (miss_count),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance n rising edges, landing 1 time unit after the last one
  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (need_valid) begin
        ok = 1'b1;
        break;
      end
      tick_n(1);
    end
  endtask

  task automatic wait_miss(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (miss_pulse) begin
        ok = 1'b1;
        break;
      end
      tick_n(1);
    end
  endtask

  initial begin
    bit ok;
    bit flag;
    bit bad;
    int pulses;
    logic [7:0] exp_mc;

    resetn        = 1'b0;
    enable        = 1'b0;
    rand_in       = 2'd0;
    need_ack      = 1'b0;
    serviced      = 1'b0;
    serviced_type = 2'd0;
    tick_n(2);
    resetn = 1'b1;
    tick_n(1);
    check("reset_state",   32'(state_dbg),   32'd0);
    check("reset_valid",   32'(need_valid),  32'd0);
    check("reset_active",  32'(need_active), 32'd0);
    check("reset_type",    32'(need_type),   32'd0);
    check("reset_pulses",  32'({done_pulse, miss_pulse}), 32'd0);
    check("reset_misscnt", 32'(miss_count),  32'd0);

    // 1: first need 12 edges after enable is sampled; rand_in only matters at expiry
    enable  = 1'b1;
    rand_in = 2'd1;
    tick_n(1);
    check("enter_wait", 32'(state_dbg), 32'd1);
    flag = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      tick_n(1);
      if (need_valid) flag = 1'b1;
    end
    check("no_early_valid", 32'(flag), 32'd0);
    rand_in = 2'd2;
    tick_n(1);
    check("valid_at_12", 32'(need_valid), 32'd1);
    check("type_at_12",  32'(need_type),  32'd2);

    // 2: ISSUE waits indefinitely, type held even if rand_in moves
    rand_in = 2'd3;
    flag = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick_n(1);
      if (!need_valid || need_active) flag = 1'b1;
    end
    check("issue_hold_valid", 32'(flag),      32'd0);
    check("issue_hold_type",  32'(need_type), 32'd2);
    need_ack = 1'b1;
    tick_n(1);
    need_ack = 1'b0;
    check("ack_valid_drop", 32'(need_valid),  32'd0);
    check("ack_active",     32'(need_active), 32'd1);

    // 3: wrong type ignored, right type completes
    serviced = 1'b1;
    serviced_type = 2'd1;
    tick_n(1);
    serviced = 1'b0;
    check("wrong_type_done",   32'(done_pulse),  32'd0);
    check("wrong_type_active", 32'(need_active), 32'd1);
    serviced = 1'b1;
    serviced_type = 2'd2;
    tick_n(1);
    serviced = 1'b0;
    check("service_done",  32'(done_pulse), 32'd1);
    check("service_state", 32'(state_dbg),  32'd1);
    tick_n(1);
    check("done_one_cycle", 32'(done_pulse), 32'd0);
    need_ack = 1'b1;
    flag = 1'b0;
    for (int i = 2; i <= 11; i++) begin
      tick_n(1);
      if (need_valid || state_dbg != 2'd1) flag = 1'b1;
    end
    need_ack = 1'b0;
    check("wait_ignores_ack", 32'(flag), 32'd0);
    rand_in = 2'd0;
    tick_n(1);
    check("next_valid_12", 32'(need_valid), 32'd1);
    check("next_type",     32'(need_type),  32'd0);

    // 4: timeout 8 edges after ack
    rand_in = 2'd3;
    need_ack = 1'b1;
    tick_n(1);
    need_ack = 1'b0;
    flag = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick_n(1);
      if (miss_pulse || !need_active) flag = 1'b1;
    end
    check("no_early_miss", 32'(flag), 32'd0);
    tick_n(1);
    check("miss_pulse_8",  32'(miss_pulse),  32'd1);
    check("miss_count_1",  32'(miss_count),  32'd1);
    check("miss_to_wait",  32'(state_dbg),   32'd1);
    tick_n(1);
    check("miss_one_cycle", 32'(miss_pulse), 32'd0);

    // service coinciding with the timeout tick
    wait_valid(20, ok);
    check("tie_wait_valid", 32'(ok),        32'd1);
    check("tie_type",       32'(need_type), 32'd3);
    need_ack = 1'b1;
    tick_n(1);
    need_ack = 1'b0;
    tick_n(7);
    serviced = 1'b1;
    serviced_type = 2'd3;
    tick_n(1);
    serviced = 1'b0;
    check("tie_done",    32'(done_pulse), 32'd1);
    check("tie_no_miss", 32'(miss_pulse), 32'd0);
    check("tie_count",   32'(miss_count), 32'd1);

    // 5: 256 timeouts, counter saturates
    exp_mc = 8'd1;
    pulses = 0;
    bad = 1'b0;
    for (int n = 0; n < 256; n++) begin
      wait_valid(20, ok);
      if (!ok) begin
        check("sat_wait_valid", 32'(ok), 32'd1);
        break;
      end
      need_ack = 1'b1;
      tick_n(1);
      need_ack = 1'b0;
      wait_miss(12, ok);
      if (!ok) begin
        check("sat_wait_miss", 32'(ok), 32'd1);
        break;
      end
      pulses++;
      exp_mc = (exp_mc == 8'd255) ? 8'd255 : exp_mc + 8'd1;
      if (miss_count !== exp_mc) bad = 1'b1;
    end
    check("sat_track",  32'(bad),        32'd0);
    check("sat_pulses", 32'(pulses),     32'd256);
    check("sat_count",  32'(miss_count), 32'd255);

    // 6a: enable dropped in ACTIVE
    wait_valid(20, ok);
    check("dis_wait_valid", 32'(ok), 32'd1);
    need_ack = 1'b1;
    tick_n(1);
    need_ack = 1'b0;
    check("dis_active_pre", 32'(need_active), 32'd1);
    enable = 1'b0;
    tick_n(1);
    check("dis_state",   32'(state_dbg),  32'd0);
    check("dis_outputs", 32'({need_valid, need_active, done_pulse, miss_pulse}), 32'd0);
    check("dis_type",    32'(need_type),  32'd0);
    check("dis_count",   32'(miss_count), 32'd255);

    // 6b: async reset while in ISSUE
    enable = 1'b1;
    rand_in = 2'd1;
    tick_n(1);
    wait_valid(20, ok);
    check("rst_wait_valid", 32'(ok),        32'd1);
    check("rst_pre_type",   32'(need_type), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("rst_async_state", 32'(state_dbg),  32'd0);
    check("rst_async_valid", 32'(need_valid), 32'd0);
    check("rst_async_type",  32'(need_type),  32'd0);
    check("rst_async_count", 32'(miss_count), 32'd0);
    tick_n(2);
    resetn = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
